// File: rtl/bram_pkg.sv
// Shared BRAM constants and the result-reader state encoding.
package bram_pkg;
  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 8;
  localparam int RES_BASE      = 128;
  localparam int NUM_ENTRIES   = 128;
  localparam int BRAM_RD_LAT   = 2;
  localparam int IDX_W         = 7;
  localparam int RR_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    RR_IDLE  = 2'd0,
    RR_RUN   = 2'd1,
    RR_DRAIN = 2'd2,
    RR_DONE  = 2'd3
  } rr_state_t;
endpackage

// File: rtl/bram_result_reader_if.sv
// Result beat stream from the reader to a downstream consumer.
// A beat transfers on a clock edge where m_valid and m_ready are both high;
// once m_valid rises, it and the payload hold until that transfer happens.
interface bram_result_reader_if #(
  parameter int DATA_W = bram_pkg::DATA_W,
  parameter int IDX_W  = bram_pkg::IDX_W
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_flag;
  logic [IDX_W-1:0]  m_index;
  logic              m_last;

  modport master (output m_valid, m_data, m_flag, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_flag, m_index, m_last, output m_ready);
endinterface

// File: rtl/bram_result_reader_fifo.sv
// result_fifo: synchronous FIFO, head entry presented on dout while not empty.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bram_result_reader.sv
// Streams RAM_B/RAM_F result entries out over a valid/ready beat interface.
// Optional RESULT_READER_FLAGCNT_EN adds flag_cnt, the count of accepted beats with m_flag set.
module bram_result_reader #(
  parameter int DEPTH      = bram_pkg::NUM_ENTRIES,
  parameter int BASE       = bram_pkg::RES_BASE,
  parameter int DATA_W     = bram_pkg::DATA_W,
  parameter int ADDR_W     = bram_pkg::ADDR_W,
  parameter int RD_LAT     = bram_pkg::BRAM_RD_LAT,
  parameter int FIFO_DEPTH = bram_pkg::RR_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   douta_b,
  output logic [ADDR_W-1:0]   addr_f,
  input  logic                douta_f,
  bram_result_reader_if.master m,
  output bram_pkg::rr_state_t state
`ifdef RESULT_READER_FLAGCNT_EN
  ,
  output logic [7:0]          flag_cnt
`endif
);
  import bram_pkg::*;

  localparam int IDX_W = bram_pkg::IDX_W;
  localparam int PW    = DATA_W + 1 + IDX_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0]  rd_idx;
  logic [RD_LAT-1:0] pipe_v;
  logic [IDX_W-1:0]  pipe_idx [RD_LAT];
  logic              issue, push, accept, full, empty;
  logic [CNT_W-1:0]  occ;
  logic [PW-1:0]     fifo_din, fifo_dout;

  assign addr_b = ADDR_W'(BASE) + ADDR_W'(rd_idx);
  assign addr_f = addr_b;

  // Credits: every issued read already owns a FIFO slot, so pushes never find it full.
  assign issue = (state == RR_RUN) && ((int'(occ) + $countones(pipe_v)) < FIFO_DEPTH);

  assign push     = pipe_v[RD_LAT-1];
  assign fifo_din = {douta_b, douta_f, pipe_idx[RD_LAT-1]};
  assign accept   = m.m_valid && m.m_ready;

  assign m.m_valid = !empty;
  assign {m.m_data, m.m_flag, m.m_index} = fifo_dout;
  assign m.m_last  = !empty && (m.m_index == LAST_IDX);

  result_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (accept),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RR_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_idx <= '0;
    end else begin
      if (issue) rd_idx <= rd_idx + IDX_W'(1);
      case (state)
        RR_IDLE: if (start) begin
          state  <= RR_RUN;
          busy   <= 1'b1;
          rd_idx <= '0;
        end
        RR_RUN: if (issue && (rd_idx == LAST_IDX)) state <= RR_DRAIN;
        RR_DRAIN: if (accept && m.m_last) begin
          state <= RR_DONE;
          done  <= 1'b1;
        end
        RR_DONE: if (!start) begin
          state <= RR_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= RR_IDLE;
      endcase
    end
  end

  // Tracks each outstanding read until its data leaves the BRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= issue;
      pipe_idx[0] <= rd_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full));

`ifdef RESULT_READER_FLAGCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_cnt <= '0;
    else if ((state == RR_IDLE) && start) flag_cnt <= '0;
    else if (accept && m.m_flag) flag_cnt <= flag_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_bram_result_reader.sv
// Directed bench for bram_result_reader with a 2-cycle BRAM model and an expected-beat queue.
module tb_bram_result_reader;
  import bram_pkg::*;

  localparam int W = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic        busy, done;
  logic [7:0]  addr_b, addr_f;
  logic [15:0] douta_b;
  logic        douta_f;
  rr_state_t   state;
`ifdef RESULT_READER_FLAGCNT_EN
  logic [7:0]  flag_cnt;
`endif

  bram_result_reader_if bus ();

  logic [15:0] ram_b [256];
  logic        ram_f [256];
  logic [15:0] b_q1, b_q2;
  logic        f_q1, f_q2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          beats, calls;
  logic [W-1:0] exp_q[$];
  logic        prev_stall;
  logic [W-1:0] held;

  // ---------------- clock / DUT / BRAM model ----------------
  always #5 clk = ~clk;

  bram_result_reader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .addr_b  (addr_b),
    .douta_b (douta_b),
    .addr_f  (addr_f),
    .douta_f (douta_f),
    .m       (bus),
    .state   (state)
`ifdef RESULT_READER_FLAGCNT_EN
    ,
    .flag_cnt(flag_cnt)
`endif
  );

  always @(posedge clk) begin
    b_q1 <= ram_b[addr_b];
    b_q2 <= b_q1;
    f_q1 <= ram_f[addr_f];
    f_q2 <= f_q1;
  end
  assign douta_b = b_q2;
  assign douta_f = f_q2;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] payload();
    return {bus.m_data, bus.m_flag, bus.m_index};
  endfunction

  function automatic int outstanding();
    int issued;
    issued = (state == RR_RUN) ? (int'(addr_b) - 128) : 128;
    return issued - beats;
  endfunction

  task automatic load_exp();
    logic [15:0] d;
    logic [6:0]  ix;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      d  = 16'(3 * i);
      ix = 7'(i);
      exp_q.push_back({d, ix[0], ix});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    calls++;
    if (prev_stall) begin
      check("hold_valid", bus.m_valid, 1);
      check("hold_payload", payload(), held);
    end
    if (busy) check("credit", (outstanding() <= 4), 1);
  endtask

  task automatic handshake(input logic rdy);
    logic [W-1:0] e;
    bus.m_ready = rdy;
    prev_stall  = bus.m_valid && !rdy;
    held        = payload();
    if (bus.m_valid && rdy) begin
      if (exp_q.size() == 0) check("extra_beat", bus.m_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("beat", payload(), e);
        check("last", bus.m_last, (e[6:0] == 7'd127));
        if (bus.m_last) check("last_data", {bus.m_data, bus.m_flag}, {16'd381, 1'b1});
      end
      beats++;
    end
  endtask

  // mode 0: ready high, 1: ready 30%, 2: 50-cycle stall at first beat, 3: stop at beat 40
  task automatic run(input int mode, input bit hold_start);
    logic rdy;
    bit   seen;
    int   first_lat, stall_left, resume_call;
    load_exp();
    beats = 0; calls = 0; prev_stall = 1'b0; seen = 1'b0;
    first_lat = 0; stall_left = 0; resume_call = 0;
    @(negedge clk);
    start = 1'b1;
    while (beats < 128 && calls < 3000) begin
      sample();
      start = hold_start;
      if (!seen && bus.m_valid) begin
        seen       = 1'b1;
        first_lat  = calls - 1;
        stall_left = (mode == 2) ? 50 : 0;
      end
      if (mode == 3 && beats == 40) return;
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 99) < 30);
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        if (stall_left == 0) begin
          check("stall_issued", int'(addr_b) - 128, 4);
          check("stall_index", bus.m_index, 0);
          resume_call = calls + 1;
        end
      end
      handshake(rdy);
    end
    check("run_beats", beats, 128);
    check("first_valid_lat", first_lat, 3);
    if (mode == 0) check("run_cycles", calls, 131);
    if (mode == 2) check("resume_rate", calls - resume_call + 1, 128);
    sample();
    check("done", done, 1);
    check("busy_in_done", busy, 1);
    check("state_done", state, RR_DONE);
    check("no_valid_done", bus.m_valid, 0);
`ifdef RESULT_READER_FLAGCNT_EN
    check("flag_cnt", flag_cnt, 64);
`endif
    if (!hold_start) begin
      sample();
      check("idle_after_done", state, RR_IDLE);
      check("busy_idle", busy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_b[i] = (i >= 128) ? 16'(3 * (i - 128)) : 16'hDEAD;
      ram_f[i] = (i >= 128) ? 1'(i - 128) : 1'b0;
    end
    bus.m_ready = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", state, RR_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.m_valid, 0);
    check("rst_last", bus.m_last, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_flag", bus.m_flag, 0);
    check("rst_index", bus.m_index, 0);
    check("rst_addr_b", addr_b, 128);
    check("rst_addr_f", addr_f, 128);
`ifdef RESULT_READER_FLAGCNT_EN
    check("rst_flag_cnt", flag_cnt, 0);
`endif
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_state", state, RR_IDLE);

    run(0, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);

    run(3, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", bus.m_valid, 0);
    check("midrst_state", state, RR_IDLE);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_addr_b", addr_b, 128);
    run(0, 1'b0);

    run(0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("hold_done_state", state, RR_DONE);
      check("hold_done", done, 1);
    end
    start = 1'b0;
    sample();
    check("drop_start_idle", state, RR_IDLE);
    run(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bram_result_reader.md
Name: bram_result_reader

Overview:
- Read-back engine for the result region of the shared BRAMs. The compute FSM writes results into RAM_B[128..255] and flags into RAM_F[128..255]; this block reads both regions back.
- On `start` it reads the 128 result/flag pairs in index order and streams them out on a valid/ready interface, e.g. to a UART/debug transmitter.
- It absorbs the 2-cycle BRAM read latency and downstream backpressure with a credit-controlled prefetch FIFO.
- It drives only the read port of RAM_B/RAM_F (address lines). It runs only while the compute FSM is idle; top-level muxing is outside this block.

Parameters:
- `DEPTH`, 128: number of result entries read per run.
- `BASE`, 128: BRAM address of entry 0 in RAM_B and RAM_F.
- `DATA_W`, 16: result width.
- `ADDR_W`, 8: BRAM address width.
- `RD_LAT`, 2: BRAM read latency in cycles.
- `FIFO_DEPTH`, 4: prefetch FIFO entries. Must be at least `RD_LAT`+2 for full throughput.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level request to begin a run; sampled in IDLE only.
- `busy`  out  1  high in RUN, DRAIN and DONE.
- `done`  out  1  high while in DONE.
- `addr_b`  out  `ADDR_W`  RAM_B read address.
- `douta_b`  in  `DATA_W`  RAM_B read data, valid `RD_LAT` cycles after the address.
- `addr_f`  out  `ADDR_W`  RAM_F read address.
- `douta_f`  in  1  RAM_F read data.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_data`  out  `DATA_W`  result value.
- `m_flag`  out  1  carry/borrow flag for the beat.
- `m_index`  out  7  entry index 0..127.
- `m_last`  out  1  high on the beat with index `DEPTH`-1.

Behaviour:
- **Reset:** state IDLE. `busy`, `done`, `m_valid`, `m_last` = 0. `m_data`, `m_flag`, `m_index` = 0. `addr_b` = `addr_f` = `BASE`. Issue counter, in-flight pipe and FIFO are cleared.
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when `start`=1.
  - RUN -> DRAIN in the cycle the last address (index `DEPTH`-1) is issued.
  - DRAIN -> DONE when the beat with `m_last` is accepted (`m_valid`&`m_ready`).
  - DONE -> IDLE when `start`=0, so `start` must drop between runs.
- **Issue:**
  - `issue` = (state==RUN) & (`occ` + `inflight` < `FIFO_DEPTH`).
  - `addr_b` = `addr_f` = `BASE` + `rd_idx` (zero-extended), presented combinationally from the `rd_idx` register.
  - `rd_idx` increments on `issue`; it is cleared on the IDLE->RUN transition.
  - Address arithmetic is modulo 2^`ADDR_W`.
- **Latency pipe:** an `RD_LAT`-deep shift register of {valid, index}. When the tail is valid, {`douta_b`, `douta_f`, index} is pushed into the FIFO in that same cycle.
- **FIFO:**
  - `m_valid` = FIFO not empty. Outputs come from the head entry (FIFO output register).
  - Pop on `m_valid`&`m_ready`.
  - Push and pop in the same cycle: occupancy is unchanged.
  - The credit rule guarantees no push when full; a push when full is an assertion failure.
  - Payload must stay stable while `m_valid`=1 and `m_ready`=0.
- **Throughput and latency:**
  - With `m_ready` held high: first `m_valid` 1+`RD_LAT` cycles after the edge that samples `start`, then one beat per cycle.
  - 128 beats complete in 128+`RD_LAT`+1 cycles.
- **Boundaries:**
  - `m_ready` low indefinitely: issue stalls once credits are exhausted. No data is lost and no reordering occurs.
  - `start` high during RUN or DRAIN: ignored.
  - Reset mid-run: in-flight reads and FIFO contents are discarded immediately; no partial beat is presented after reset.

Optional Feature:
- **`RESULT_READER_FLAGCNT_EN` defined:**
  - Adds output `flag_cnt` [7:0], the count of accepted beats with `m_flag`=1.
  - Cleared to 0 on reset and on the IDLE->RUN transition.
  - Holds its final value through DONE and IDLE.
  - Range 0..128, no wrap.
- **Not defined:** the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- **Shared package `bram_pkg`:** `DATA_W`, `ADDR_W`, `RES_BASE` (128), `NUM_ENTRIES` (128), `BRAM_RD_LAT` (2), and the reader state encoding `RR_IDLE`/`RR_RUN`/`RR_DRAIN`/`RR_DONE` (2-bit).
- **Sub-module `result_fifo`:** synchronous FIFO with parameterised width/depth and ports push/pop/full/empty/count. It is reusable by the future loader block.

Test Plan:
- **Reset values:** assert `rst` for 3 cycles with `start`=1 -> all outputs at reset values, `addr_b`=128, no `m_valid`.
- **Full-rate run:** BRAM model with RAM_B[128+i]=i*3, RAM_F[128+i]=i[0]; `m_ready`=1; pulse `start` -> first `m_valid` at cycle 3 with `m_data`=0. Then 128 consecutive beats, `m_data`=3*`m_index`. `m_last` only at index 127 (`m_data`=381, `m_flag`=1). `done` follows; with FLAGCNT_EN, `flag_cnt`=64.
- **Backpressure:** `m_ready` random at 30% high -> beats in order 0..127 with no gaps or duplicates. Payload stable while stalled. In-flight + FIFO occupancy never exceeds 4.
- **Long stall:** `m_ready`=0 for 50 cycles after the first beat -> exactly 4 addresses issued, `m_index` held at 0. Resume -> stream continues at 1 beat/cycle.
- **Reset mid-run:** `rst` pulse at beat 40 -> `m_valid` low immediately, state IDLE. A new `start` restarts from index 0 and `addr_b`=128.
- **Start handshake:** hold `start`=1 after `done` -> stays in DONE with `done`=1. Drop `start` -> IDLE; raise `start` again -> second full run identical to the first.
